gpio_edge_irq: RTL and testbench
================================

Name: gpio_edge_irq

Overview:
- Downstream consumer of GPIO_core read_port_o (already 2-flop synchronised).
- Per-bit digital debounce on each input.
- Rising/falling edge detection on the debounced level.
- Sticky per-bit pending flags, write-1-to-clear.
- Single level interrupt line for the CPU bus bridge.

Parameters:
- WIDTH_PORT, 8, number of GPIO bits; must match GPIO_core.
- DB_CYCLES, 4, consecutive cycles a new level must persist before it is accepted; legal range 1..65535.
- CNT_W, $clog2(DB_CYCLES+1), debounce counter width; derived, do not override.

Ports:
- clk_i  input  1  system clock.
- resetn_i  input  1  reset, asynchronous, active-low.
- gpi_i  input  WIDTH_PORT  synchronised pin levels (from GPIO_core read_port_o).
- rise_en_i  input  WIDTH_PORT  per-bit enable for setting pending on a rising edge.
- fall_en_i  input  WIDTH_PORT  per-bit enable for setting pending on a falling edge.
- irq_en_i  input  WIDTH_PORT  per-bit mask for contribution to irq_o.
- clr_we_i  input  1  clear strobe, one cycle.
- clr_mask_i  input  WIDTH_PORT  bits to clear when clr_we_i=1 (write-1-to-clear).
- db_level_o  output  WIDTH_PORT  debounced level, registered.
- pending_o  output  WIDTH_PORT  sticky edge flags, registered.
- irq_o  output  1  interrupt request, registered, active-high level.

Behaviour:
- Reset (resetn_i=0, asynchronous):
  - db_level_o=0, pending_o=0, irq_o=0.
  - All debounce counters=0.
  - All edge events suppressed.
- Debounce, independent per bit b, each rising clk_i edge:
  - gpi_i[b]==db_level_o[b]: cnt[b]<=0.
  - Else if cnt[b]==DB_CYCLES-1: db_level_o[b]<=gpi_i[b], cnt[b]<=0, and an edge event is raised for that cycle.
  - Else: cnt[b]<=cnt[b]+1.
- Debounce latency: a new level held for exactly DB_CYCLES sampled cycles appears on db_level_o at the end of the DB_CYCLES-th cycle.
  - Any glitch shorter than DB_CYCLES cycles resets the count and never reaches db_level_o.
  - DB_CYCLES=1 degenerates to a plain one-cycle register.
- Edge events are combinational from the accept condition above:
  - rise[b] = accept[b] & gpi_i[b].
  - fall[b] = accept[b] & ~gpi_i[b].
  - Any input level present during reset exits reset as a normal debounce candidate against 0. A high pin therefore produces a rise event DB_CYCLES cycles after reset release.
- Pending, same edge as db_level_o update:
  - set[b] = (rise[b]&rise_en_i[b]) | (fall[b]&fall_en_i[b]).
  - clr[b] = clr_we_i & clr_mask_i[b].
  - pending_o[b] <= set[b] ? 1 : (clr[b] ? 0 : pending_o[b]).
  - Set wins over a simultaneous clear, so no edge is lost.
  - Enables are sampled only in the event cycle. Changing rise_en_i/fall_en_i does not alter existing pending bits.
- irq_o <= |(pending_o & irq_en_i), registered.
  - irq_o rises one cycle after the pending bit sets.
  - irq_o falls one cycle after the last enabled pending bit clears or its irq_en_i drops.
- Reset asserted mid-debounce discards partial counts. Reset asserted while pending discards the flags; no irq_o glitch on reset release.
- No combinational path from any input to any output.

Test Plan:
1. Reset with gpi_i=8'h00, release, hold 20 cycles -> db_level_o=8'h00, pending_o=8'h00, irq_o=0 throughout.
2. DB_CYCLES=4, rise_en_i=8'hFF, irq_en_i=8'hFF; drive gpi_i=8'h01 and hold:
   - db_level_o[0]=1 exactly 4 cycles after the change, pending_o=8'h01 the same cycle.
   - irq_o=1 one cycle later.
3. With bit 1 low, pulse gpi_i[1] high for 3 cycles, then low -> db_level_o[1] stays 0, pending_o[1] stays 0, no irq.
4. fall_en_i=8'h80, rise_en_i=8'h00; gpi_i[7] high, then low, each held 6 cycles:
   - db_level_o[7] follows both transitions.
   - pending_o=8'h80 only after the falling edge.
5. pending_o=8'h81; pulse clr_we_i with clr_mask_i=8'h01:
   - pending_o=8'h80 next cycle, irq_o stays 1.
   - Second clear with mask 8'h80 -> pending_o=8'h00, irq_o=0 one cycle later.
6. Simultaneous events and masking:
   - Clear of bit 0 issued in the same cycle as a new accepted rise on bit 0 -> pending_o[0] remains 1.
   - With irq_en_i=8'h00 and pending_o nonzero -> irq_o=0.
   - Assert resetn_i mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// gpio_edge_irq : per-bit debounce, rise/fall edge detect, sticky W1C pending
//                 flags and a single registered level interrupt.
// Revision      : 1.0
// ============================================================================
module gpio_edge_irq #(
    parameter int WIDTH_PORT = 8,
    parameter int DB_CYCLES  = 4,
    parameter int CNT_W      = $clog2(DB_CYCLES + 1)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [WIDTH_PORT-1:0] gpi_i,
    input  logic [WIDTH_PORT-1:0] rise_en_i,
    input  logic [WIDTH_PORT-1:0] fall_en_i,
    input  logic [WIDTH_PORT-1:0] irq_en_i,
    input  logic                  clr_we_i,
    input  logic [WIDTH_PORT-1:0] clr_mask_i,
    output logic [WIDTH_PORT-1:0] db_level_o,
    output logic [WIDTH_PORT-1:0] pending_o,
    output logic                  irq_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH_PORT-1:0] db_level_d, db_level_q;
    logic [WIDTH_PORT-1:0] pending_d,  pending_q;
    logic                  irq_d,      irq_q;

    logic [WIDTH_PORT-1:0] w_accept;
    logic [WIDTH_PORT-1:0] w_rise;
    logic [WIDTH_PORT-1:0] w_fall;
    logic [WIDTH_PORT-1:0] w_set;
    logic [WIDTH_PORT-1:0] w_clr;

    // The counter tracks how many consecutive cycles the pin has disagreed
    // with the debounced level; agreement at any point restarts it.
    for (genvar b = 0; b < WIDTH_PORT; b++) begin : g_bit
        logic [CNT_W-1:0] cnt_d, cnt_q;
        logic             w_differs;

        assign w_differs   = gpi_i[b] ^ db_level_q[b];
        assign w_accept[b] = w_differs && (cnt_q == C_CNT_MAX);

        always_comb begin
            cnt_d = cnt_q;
            if (!w_differs || w_accept[b]) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk_i or negedge resetn_i) begin
            if (!resetn_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign w_rise = w_accept &  gpi_i;
    assign w_fall = w_accept & ~gpi_i;
    assign w_set  = (w_rise & rise_en_i) | (w_fall & fall_en_i);
    assign w_clr  = clr_we_i ? clr_mask_i : '0;

    // Set dominates clear so an edge landing on a clear write is never lost.
    always_comb begin
        db_level_d = (db_level_q & ~w_accept) | (gpi_i & w_accept);
        pending_d  = w_set | (pending_q & ~w_clr);
        irq_d      = |(pending_q & irq_en_i);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            db_level_q <= '0;
            pending_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            db_level_q <= db_level_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
        end
    end

    assign db_level_o = db_level_q;
    assign pending_o  = pending_q;
    assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// tb_gpio_edge_irq : directed and randomized checks against a sample-history
//                    reference model of debounce, pending and interrupt.
// Revision         : 1.0
// ============================================================================
module tb_gpio_edge_irq;

    localparam int W  = 8;
    localparam int DB = 4;

    logic         clk_i = 1'b0;
    logic         resetn_i;
    logic [W-1:0] gpi_i;
    logic [W-1:0] rise_en_i;
    logic [W-1:0] fall_en_i;
    logic [W-1:0] irq_en_i;
    logic         clr_we_i;
    logic [W-1:0] clr_mask_i;
    logic [W-1:0] db_level_o;
    logic [W-1:0] pending_o;
    logic         irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last DB samples since reset, plus the architectural outputs.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_db;
    logic [W-1:0] m_pend;
    logic         m_irq;

    gpio_edge_irq #(
        .WIDTH_PORT (W),
        .DB_CYCLES  (DB)
    ) u_dut (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .gpi_i      (gpi_i),
        .rise_en_i  (rise_en_i),
        .fall_en_i  (fall_en_i),
        .irq_en_i   (irq_en_i),
        .clr_we_i   (clr_we_i),
        .clr_mask_i (clr_mask_i),
        .db_level_o (db_level_o),
        .pending_o  (pending_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_db   = '0;
        m_pend = '0;
        m_irq  = 1'b0;
    endtask

    // A bit is accepted when each of the last DB samples disagreed with the
    // debounced level it had at that time.
    task automatic model_step();
        logic [W-1:0] acc;
        logic [W-1:0] set_v;
        logic [W-1:0] clr_v;
        hist.push_back(gpi_i);
        if (hist.size() > DB) void'(hist.pop_front());
        acc = '0;
        if (hist.size() == DB) begin
            acc = '1;
            foreach (hist[i]) acc &= hist[i] ^ m_db;
        end
        set_v  = (acc & gpi_i & rise_en_i) | (acc & ~gpi_i & fall_en_i);
        clr_v  = clr_we_i ? clr_mask_i : '0;
        m_irq  = |(m_pend & irq_en_i);
        m_pend = set_v | (m_pend & ~clr_v);
        m_db   = (m_db & ~acc) | (gpi_i & acc);
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (!resetn_i) model_reset();
        else           model_step();
        #1;
        check_eq("db_level", 32'(db_level_o), 32'(m_db));
        check_eq("pending",  32'(pending_o),  32'(m_pend));
        check_eq("irq",      32'(irq_o),      32'(m_irq));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        resetn_i = 1'b0;
        #1;
        model_reset();
        check_eq({tag, "_db"},  32'(db_level_o), 32'h0);
        check_eq({tag, "_pnd"}, 32'(pending_o),  32'h0);
        check_eq({tag, "_irq"}, 32'(irq_o),      32'h0);
        ticks(2);
        resetn_i = 1'b1;
    endtask

    initial begin
        resetn_i   = 1'b0;
        gpi_i      = '0;
        rise_en_i  = '0;
        fall_en_i  = '0;
        irq_en_i   = '0;
        clr_we_i   = 1'b0;
        clr_mask_i = '0;
        model_reset();
        #3;
        check_eq("rst_db",  32'(db_level_o), 32'h0);
        check_eq("rst_pnd", 32'(pending_o),  32'h0);
        check_eq("rst_irq", 32'(irq_o),      32'h0);
        ticks(2);
        resetn_i = 1'b1;
        ticks(20);

        // Single rising pin: visible on the 4th sampled edge, irq one later.
        rise_en_i = '1;
        irq_en_i  = '1;
        gpi_i     = 8'h01;
        ticks(3);
        check_eq("db_before_accept", 32'(db_level_o), 32'h00);
        tick();
        check_eq("db_at_accept",  32'(db_level_o), 32'h01);
        check_eq("pnd_at_accept", 32'(pending_o),  32'h01);
        check_eq("irq_not_yet",   32'(irq_o),      32'h0);
        tick();
        check_eq("irq_one_later", 32'(irq_o),      32'h1);

        // Glitch of DB-1 cycles on bit 1 must be filtered.
        gpi_i = 8'h03;
        ticks(3);
        gpi_i = 8'h01;
        ticks(6);
        check_eq("glitch_db",  32'(db_level_o), 32'h01);
        check_eq("glitch_pnd", 32'(pending_o),  32'h01);

        // Falling-only enable on bit 7.
        rise_en_i = 8'h00;
        fall_en_i = 8'h80;
        gpi_i     = 8'h81;
        ticks(6);
        check_eq("b7_high_db",  32'(db_level_o), 32'h81);
        check_eq("b7_high_pnd", 32'(pending_o),  32'h01);
        gpi_i = 8'h01;
        ticks(6);
        check_eq("b7_low_db",  32'(db_level_o), 32'h01);
        check_eq("b7_low_pnd", 32'(pending_o),  32'h81);

        // Write-1-to-clear, one bit at a time.
        clr_we_i   = 1'b1;
        clr_mask_i = 8'h01;
        tick();
        clr_we_i   = 1'b0;
        check_eq("clr0_pnd", 32'(pending_o), 32'h80);
        tick();
        check_eq("clr0_irq", 32'(irq_o), 32'h1);
        clr_we_i   = 1'b1;
        clr_mask_i = 8'h80;
        tick();
        clr_we_i   = 1'b0;
        check_eq("clr7_pnd", 32'(pending_o), 32'h00);
        tick();
        check_eq("clr7_irq", 32'(irq_o), 32'h0);

        // Clear colliding with an accepted fall on bit 0: set wins.
        fall_en_i = 8'h01;
        gpi_i     = 8'h00;
        ticks(3);
        clr_we_i   = 1'b1;
        clr_mask_i = 8'h01;
        tick();
        clr_we_i   = 1'b0;
        check_eq("set_beats_clr", 32'(pending_o), 32'h01);

        // Masked interrupt.
        irq_en_i = 8'h00;
        ticks(2);
        check_eq("masked_irq", 32'(irq_o), 32'h0);

        // Reset mid-count discards everything.
        irq_en_i = '1;
        gpi_i    = 8'hFF;
        ticks(2);
        async_reset_check("midcount");
        ticks(DB + 2);

        // Randomized phase.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 7) == 0) gpi_i[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) rise_en_i = W'($urandom);
            if ($urandom_range(0, 31) == 0) fall_en_i = W'($urandom);
            if ($urandom_range(0, 31) == 0) irq_en_i  = W'($urandom);
            clr_we_i   = ($urandom_range(0, 5) == 0);
            clr_mask_i = W'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset_check("rand_rst");
            else                             tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
